// File: rtl/groot_param.sv
// Stochastic generalised-root unit: out density tends to p^(1/ORDER) for input density p.
// Optional debug ports cnt_o/sat_o are enabled by defining GROOT_CNT_OUT_EN.
module groot_param #(
  parameter int WIDTH = 5,
  parameter int ORDER = 2,
  parameter int INIT  = 2 ** (WIDTH - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             init_ld,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] randNum,
  input  logic             in,
  output logic             out
`ifdef GROOT_CNT_OUT_EN
  ,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
`endif
);

  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  // Reject illegal parameter sets at elaboration.
  generate
    if ((WIDTH < 2) || (WIDTH > 16) || (ORDER < 1) || (ORDER > 8) ||
        (INIT < 0) || (INIT > (2 ** WIDTH) - 1)) begin : g_bad_param
      $error("groot_param: WIDTH, ORDER or INIT out of legal range");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_r;
  logic             dec_s;

  // Output bit: counter compared against the fresh random number.
  always_comb begin
    out = (cnt_r >= randNum);
  end

  // Delayed copies of out; the decrement fires only when out and every tap are high.
  generate
    if (ORDER >= 2) begin : g_hist
      logic [ORDER-2:0] hist_r;
      logic [ORDER-2:0] hist_nxt_s;

      // Shift the current output into the tap line.
      always_comb begin
        hist_nxt_s    = hist_r << 1'b1;
        hist_nxt_s[0] = out;
      end

      // Tap register; cleared by reset and by a counter load.
      always_ff @(posedge clk) begin
        if (rst) begin
          hist_r <= '0;
        end else if (en) begin
          if (init_ld) begin
            hist_r <= '0;
          end else begin
            hist_r <= hist_nxt_s;
          end
        end else begin
          hist_r <= hist_r;
        end
      end

      assign dec_s = out & (&hist_r);
    end else begin : g_no_hist
      assign dec_s = out;
    end
  endgenerate

  // Saturating up/down counter with load; inc and dec together cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= INIT_V;
    end else if (en) begin
      if (init_ld) begin
        cnt_r <= init_val;
      end else begin
        case ({in, dec_s})
          2'b10: begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + 1'b1;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          2'b01: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - 1'b1;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          default: cnt_r <= cnt_r;
        endcase
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef GROOT_CNT_OUT_EN
  // Debug view of the counter and its saturation status.
  always_comb begin
    cnt_o = cnt_r;
    sat_o = (cnt_r == '0) || (cnt_r == CNT_MAX);
  end
`endif

endmodule

// File: tb/tb_groot_param.sv
// Scoreboard bench for groot_param: ORDER 1, 2 and 3 instances checked against a
// run-length reference model, plus directed saturation/load probes and density checks.
module tb_groot_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       init_ld = 1'b0;
  logic [4:0] init_val = 5'd0;
  logic [4:0] randNum = 5'd0;
  logic       in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
  logic       o1, o2, o3;
`ifdef GROOT_CNT_OUT_EN
  logic [4:0] c1, c2, c3;
  logic       s1, s2, s3;
`endif

  always #5 clk = ~clk;

  groot_param #(.WIDTH(5), .ORDER(1), .INIT(16)) d1 (
    .clk(clk), .rst(rst), .en(en), .init_ld(init_ld), .init_val(init_val),
    .randNum(randNum), .in(in1), .out(o1)
`ifdef GROOT_CNT_OUT_EN
    , .cnt_o(c1), .sat_o(s1)
`endif
  );
  groot_param #(.WIDTH(5), .ORDER(2), .INIT(16)) d2 (
    .clk(clk), .rst(rst), .en(en), .init_ld(init_ld), .init_val(init_val),
    .randNum(randNum), .in(in2), .out(o2)
`ifdef GROOT_CNT_OUT_EN
    , .cnt_o(c2), .sat_o(s2)
`endif
  );
  groot_param #(.WIDTH(5), .ORDER(3), .INIT(16)) d3 (
    .clk(clk), .rst(rst), .en(en), .init_ld(init_ld), .init_val(init_val),
    .randNum(randNum), .in(in3), .out(o3)
`ifdef GROOT_CNT_OUT_EN
    , .cnt_o(c3), .sat_o(s3)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  int         cq[$];
  bit         chk = 1'b0;
  bit         meas = 1'b0;
  int         ones[3];

  // Reference model: counter value and length of the current run of 1s in out
  // (since reset/load). Instance k has ORDER k+1, so it decrements when out=1
  // and the previous k outputs were all 1.
  int mcnt[3];
  int run[3];

  function automatic logic [2:0] model_out(input logic [4:0] rn);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = (mcnt[k] >= int'(rn));
    return r;
  endfunction

  function automatic void model_edge(input bit r, input bit e, input bit ld,
                                     input logic [4:0] v, input logic [4:0] rn,
                                     input bit [2:0] inv);
    for (int k = 0; k < 3; k++) begin
      bit o, dec;
      o   = (mcnt[k] >= int'(rn));
      dec = o && (run[k] >= k);
      if (r) begin
        mcnt[k] = 16; run[k] = 0;
      end else if (e) begin
        if (ld) begin
          mcnt[k] = int'(v); run[k] = 0;
        end else begin
          if (inv[k] && !dec && mcnt[k] < 31) mcnt[k] = mcnt[k] + 1;
          else if (!inv[k] && dec && mcnt[k] > 0) mcnt[k] = mcnt[k] - 1;
          run[k] = o ? run[k] + 1 : 0;
        end
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit ld, input logic [4:0] v,
                     input logic [4:0] rn, input bit [2:0] inv, input bit c);
    rst = r; en = e; init_ld = ld; init_val = v; randNum = rn;
    {in3, in2, in1} = inv; chk = c;
    if (c) begin
      exp_q.push_back(model_out(rn));
`ifdef GROOT_CNT_OUT_EN
      cq.push_back(mcnt[1]);
`endif
    end
    @(posedge clk);
    model_edge(r, e, ld, v, rn, inv);
    #1;
  endtask

  // en=0 probe: state frozen, out shows cnt >= rn; masked bits use spec constants.
  task automatic probe(input logic [4:0] rn, input logic [2:0] ex, input logic [2:0] mask,
                       input bit ld, input logic [4:0] v);
    rst = 1'b0; en = 1'b0; init_ld = ld; init_val = v; randNum = rn;
    {in3, in2, in1} = 3'b111; chk = 1'b1;
    exp_q.push_back((ex & mask) | (model_out(rn) & ~mask));
`ifdef GROOT_CNT_OUT_EN
    cq.push_back(mcnt[1]);
`endif
    @(posedge clk);
    model_edge(1'b0, 1'b0, ld, v, rn, 3'b111);
    #1;
  endtask

  // Monitor: pops one expectation per checked cycle and compares on the falling edge.
  logic [2:0] mon_e, mon_a;
  always @(negedge clk) begin
    if (chk) begin
      mon_a = {o3, o2, o1};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (mon_a[k] !== mon_e[k]) begin
            errors++;
            $display("FAIL out_order%0d got %b want %b rn=%0d at %0t",
                     k + 1, mon_a[k], mon_e[k], randNum, $time);
          end
        end
      end
`ifdef GROOT_CNT_OUT_EN
      if (cq.size() != 0) begin
        int ec;
        ec = cq.pop_front();
        checks++;
        if (int'(c2) != ec || s2 !== (ec == 0 || ec == 31)) begin
          errors++;
          $display("FAIL cnt_o got %0d/%b want %0d", c2, s2, ec);
        end
      end
`endif
      if (meas) begin
        ones[0] += int'(o1); ones[1] += int'(o2); ones[2] += int'(o3);
      end
    end
  end

  task automatic density(input int k, input real lo, input real hi);
    real d;
    d = real'(ones[k]) / 4096.0;
    checks++;
    if (d < lo || d > hi) begin
      errors++;
      $display("FAIL density_order%0d got %f want %f..%f", k + 1, d, lo, hi);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin mcnt[k] = 0; run[k] = 0; ones[k] = 0; end
    @(posedge clk); #1;

    // Reset (overriding en/init_ld) then compare boundary around INIT=16.
    cyc(1'b1, 1'b1, 1'b1, 5'd3, 5'd9, 3'b111, 1'b0);
    probe(5'd15, 3'b111, 3'b111, 1'b0, 5'd0);
    probe(5'd16, 3'b111, 3'b111, 1'b0, 5'd0);
    probe(5'd17, 3'b000, 3'b111, 1'b0, 5'd0);

    // Upper saturation: 15 increments reach 31, then hold without wrap.
    repeat (14) cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd31, 3'b111, 1'b1);
    probe(5'd31, 3'b000, 3'b111, 1'b0, 5'd0);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd31, 3'b111, 1'b1);
    probe(5'd31, 3'b111, 3'b111, 1'b0, 5'd0);
    repeat (20) cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd31, 3'b111, 1'b1);
    probe(5'd31, 3'b111, 3'b111, 1'b0, 5'd0);

    // Lower saturation: ORDER=2 holds the first cycle, reaches 0 after 17.
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1);
    repeat (16) cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1);
    probe(5'd1, 3'b010, 3'b010, 1'b0, 5'd0);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1);
    probe(5'd1, 3'b000, 3'b010, 1'b0, 5'd0);
    probe(5'd0, 3'b111, 3'b111, 1'b0, 5'd0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1);
    probe(5'd1, 3'b000, 3'b111, 1'b0, 5'd0);
    probe(5'd31, 3'b000, 3'b111, 1'b0, 5'd0);

    // Enable and load.
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 3'b111, 1'b1);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 5'($urandom), 5'($urandom), 3'b111, 1'b1);
    probe(5'd16, 3'b111, 3'b111, 1'b0, 5'd0);
    probe(5'd17, 3'b000, 3'b111, 1'b0, 5'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b111, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 5'($urandom), 3'b111, 1'b1);
    probe(5'd7, 3'b111, 3'b111, 1'b0, 5'd0);
    probe(5'd8, 3'b000, 3'b111, 1'b1, 5'd20);
    probe(5'd8, 3'b000, 3'b111, 1'b0, 5'd0);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1);
    probe(5'd7, 3'b010, 3'b010, 1'b0, 5'd0);

    // Random mixed traffic including loads, enables and mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 31) == 0, 5'($urandom), 5'($urandom),
          3'($urandom), 1'b1);
    end

    // Convergence: p = 0.3 / 0.25 / 0.125 for ORDER 1 / 2 / 3.
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1);
    for (int i = 0; i < 256 + 4096; i++) begin
      bit [2:0] inv;
      inv[0] = ($urandom_range(0, 999) < 300);
      inv[1] = ($urandom_range(0, 3) == 0);
      inv[2] = ($urandom_range(0, 7) == 0);
      meas = (i >= 256);
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'($urandom), inv, 1'b1);
    end
    meas = 1'b0;
    density(0, 0.26, 0.34);
    density(1, 0.46, 0.54);
    density(2, 0.45, 0.55);

    // Reset mid-stream leaves no residue.
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'($urandom), 3'b101, 1'b1);
    probe(5'd16, 3'b111, 3'b111, 1'b0, 5'd0);
    probe(5'd17, 3'b000, 3'b111, 1'b0, 5'd0);

    chk = 1'b0;
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
